// File: rtl/pmips_boot_loader_pkg.sv
// rtl/pmips_boot_loader_pkg.sv - shared state encodings and frame field widths for the boot loader
package pmips_boot_loader_pkg;

    localparam int CNT_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        LOAD  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } bootState_t;

endpackage

// File: rtl/pmips_byte_packer.sv
// rtl/pmips_byte_packer.sv - assembles LSB-first stream bytes into instruction words
module pmips_byte_packer #(
    parameter int BYTE_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                byteValid,
    input  logic [BYTE_W-1:0]   byteData,
    output logic [1:0]          byteIdx,
    output logic [4*BYTE_W-1:0] word,
    output logic                wordValid
);

    logic [3*BYTE_W-1:0] partial;

    // The 4th byte goes straight into the word register, so wordValid is a one-cycle pulse
    // following that byte and can never repeat on consecutive cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byteIdx   <= 2'd0;
            partial   <= '0;
            word      <= '0;
            wordValid <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            if (clear) begin
                byteIdx <= 2'd0;
            end else if (byteValid) begin
                byteIdx <= byteIdx + 2'd1;
                case (byteIdx)
                    2'd0: partial[0 +: BYTE_W]        <= byteData;
                    2'd1: partial[BYTE_W +: BYTE_W]   <= byteData;
                    2'd2: partial[2*BYTE_W +: BYTE_W] <= byteData;
                    default: begin
                        word      <= {byteData, partial};
                        wordValid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pmips_boot_loader.sv
// rtl/pmips_boot_loader.sv - framed byte-stream program loader that holds the MIPS core in reset until verified
module pmips_boot_loader
    import pmips_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                 MAX_WORDS_I = 1 << ADDR_W;
    localparam logic [CNT_W:0]     MAX_WORDS   = MAX_WORDS_I[CNT_W:0];

    bootState_t        state, nextState;
    logic [BYTE_W-1:0] cntLo;
    logic [BYTE_W-1:0] csum;
    logic [CNT_W-1:0]  lastIdx;
    logic [CNT_W-1:0]  hdrCount;
    logic [ADDR_W-1:0] addr;
    logic              cpuRstN;
    logic              xfer;
    logic              loadByte;
    logic              enterHdr0;
    logic              oversize;
    logic [1:0]        byteIdx;
    logic [WORD_W-1:0] word;
    logic              wordValid;

    assign hdrCount  = {rx_data, cntLo};
    // 17-bit compare so a count of exactly 2**ADDR_W stays legal and larger ones never wrap
    assign oversize  = {1'b0, hdrCount} > MAX_WORDS;
    assign xfer      = rx_valid && rx_ready;
    assign loadByte  = xfer && (state == LOAD);
    assign enterHdr0 = (nextState == HDR0) && (state != HDR0);

    always_comb begin
        nextState = state;
        rx_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = HDR0;
            end
            HDR0: begin
                rx_ready = 1'b1;
                if (xfer) nextState = HDR1;
            end
            HDR1: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    if (hdrCount == '0)  nextState = CSUM;
                    else if (oversize)   nextState = ERROR;
                    else                 nextState = LOAD;
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                // addr already equals the current word index: it advanced during earlier byte slots
                if (xfer && byteIdx == 2'd3 && CNT_W'(addr) == lastIdx) nextState = CSUM;
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (xfer) nextState = (rx_data == csum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) nextState = HDR0;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cntLo   <= '0;
            csum    <= '0;
            lastIdx <= '0;
            addr    <= '0;
            cpuRstN <= 1'b0;
        end else begin
            state   <= nextState;
            cpuRstN <= (nextState == DONE);
            if (xfer && state == HDR0) cntLo <= rx_data;
            if (xfer && state == HDR1) lastIdx <= hdrCount - 1'b1;
            if (enterHdr0) begin
                csum <= '0;
                addr <= '0;
            end else begin
                if (loadByte)  csum <= csum ^ rx_data;
                if (wordValid) addr <= addr + 1'b1;
            end
        end
    end

    pmips_byte_packer #(
        .BYTE_W(BYTE_W)
    ) u_packer (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (enterHdr0),
        .byteValid(loadByte),
        .byteData (rx_data),
        .byteIdx  (byteIdx),
        .word     (word),
        .wordValid(wordValid)
    );

    assign imem_we    = wordValid;
    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign cpu_rst_n  = cpuRstN;
    assign busy       = (state == HDR0) || (state == HDR1) || (state == LOAD) || (state == CSUM);
    assign done       = (state == DONE);
    assign error      = (state == ERROR);

endmodule

// File: tb/tb_pmips_boot_loader.sv
// tb/tb_pmips_boot_loader.sv - directed self-checking bench for the boot loader
module tb_pmips_boot_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int b2b    = 0;
    logic prevWe = 1'b0;

    logic [7:0]  wAddr[$];
    logic [31:0] wData[$];
    logic [31:0] img[0:255];

    pmips_boot_loader #(.ADDR_W(8), .BYTE_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we) begin
            wAddr.push_back(imem_addr);
            wData.push_back(imem_wdata);
            if (prevWe) b2b <= b2b + 1;
        end
        prevWe <= imem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = rx_ready;
            tick();
        end
        rx_valid = 1'b0;
        if (!ok) begin
            errors++;
            $error("FAIL byte_accept observed=timeout expected=accepted byte %h", b);
        end
    endtask

    task automatic send_payload(input int n, input int maxGap, output logic [7:0] cs);
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b  = img[w][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, $urandom_range(0, maxGap));
            end
        end
    endtask

    task automatic check_writes(input string tag, input int n);
        int mism = 0;
        check({tag, "_count"}, wAddr.size(), n);
        for (int i = 0; i < wAddr.size() && i < n; i++) begin
            logic [7:0] ea;
            ea = i[7:0];
            if (wAddr[i] !== ea || wData[i] !== img[i]) mism++;
        end
        check({tag, "_content"}, mism, 0);
    endtask

    initial begin
        logic [7:0] cs;
        int cnt;
        RST = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        RST = 1'b1;
        tick();

        // nominal two-word image; rx_valid already high at start must not be consumed in IDLE
        img[0] = 32'h20080013; img[1] = 32'h20090005;
        rx_valid = 1'b1; rx_data = 8'h02;
        pulse_start();
        check("hdr0_busy", busy, 1);
        check("hdr0_rx_ready", rx_ready, 1);
        wAddr.delete(); wData.delete();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h08, 0); send_byte(8'h20, 0);
        check("w0_we", imem_we, 1);
        check("w0_addr", imem_addr, 8'h00);
        check("w0_data", imem_wdata, 32'h20080013);
        send_byte(8'h05, 0);
        check("w0_we_single", imem_we, 0);
        send_byte(8'h00, 0); send_byte(8'h09, 0); send_byte(8'h20, 0);
        check("w1_we", imem_we, 1);
        check("w1_addr", imem_addr, 8'h01);
        check("w1_data", imem_wdata, 32'h20090005);
        check("pre_csum_cpu_rst_n", cpu_rst_n, 0);
        send_byte(8'h17, 0);
        check("nom_done", done, 1);
        check("nom_cpu_rst_n", cpu_rst_n, 1);
        check("nom_busy", busy, 0);
        check("nom_error", error, 0);
        check("nom_rx_ready", rx_ready, 0);
        check_writes("nom", 2);

        // bad checksum
        pulse_start();
        check("reload_cpu_rst_n_low", cpu_rst_n, 0);
        wAddr.delete(); wData.delete();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_payload(2, 0, cs);
        send_byte(8'h16, 0);
        check("badcs_error", error, 1);
        check("badcs_done", done, 0);
        check("badcs_cpu_rst_n", cpu_rst_n, 0);
        repeat (2) tick();
        check_writes("badcs", 2);
        pulse_start();
        check("err_restart_error", error, 0);
        check("err_restart_busy", busy, 1);

        // N = 0
        wAddr.delete(); wData.delete();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("n0_done", done, 1);
        check("n0_cpu_rst_n", cpu_rst_n, 1);
        check("n0_writes", wAddr.size(), 0);

        // N = 0x0101 is oversize for a 256-word memory
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        check("ovr_error", error, 1);
        check("ovr_rx_ready", rx_ready, 0);
        repeat (3) tick();
        check("ovr_writes", wAddr.size(), 0);
        check("ovr_cpu_rst_n", cpu_rst_n, 0);

        // N = 256 fills the whole memory
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            img[i] = {v ^ 8'hA5, v, 8'h3C, ~v};
        end
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_payload(256, 0, cs);
        send_byte(cs, 0);
        check("full_done", done, 1);
        check_writes("full", 256);
        check("full_last_addr", wAddr[wAddr.size()-1], 8'hFF);

        // stalls and ignored start pulses during LOAD
        img[0] = 32'h20080013; img[1] = 32'h20090005;
        pulse_start();
        wAddr.delete(); wData.delete();
        send_byte(8'h02, 3); send_byte(8'h00, 5);
        send_byte(8'h13, 2); send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'h08, 4); send_byte(8'h20, 1);
        pulse_start();
        send_byte(8'h05, 5); send_byte(8'h00, 3); send_byte(8'h09, 0); send_byte(8'h20, 2);
        check("stall_busy", busy, 1);
        send_byte(8'h17, 4);
        check("stall_done", done, 1);
        check_writes("stall", 2);

        // reload from DONE
        pulse_start();
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        check("reload_done", done, 0);
        img[0] = 32'hDEADBEEF;
        wAddr.delete(); wData.delete();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        send_byte(8'h22, 0);
        check("reload2_done", done, 1);
        check("reload2_cpu_rst_n", cpu_rst_n, 1);
        check_writes("reload2", 1);

        // asynchronous reset mid-LOAD after 6 payload bytes
        img[0] = 32'h20080013; img[1] = 32'h20090005;
        pulse_start();
        wAddr.delete(); wData.delete();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h08, 0);
        send_byte(8'h20, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
        #2 RST = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rx_ready", rx_ready, 0);
        check("arst_addr", imem_addr, 0);
        check("arst_wdata", imem_wdata, 0);
        cnt = wAddr.size();
        repeat (4) tick();
        check("arst_no_writes", wAddr.size(), cnt);
        check("arst_cpu_rst_n", cpu_rst_n, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        RST = 1'b1;
        repeat (2) tick();
        check("post_rst_idle_ready", rx_ready, 0);
        check("post_rst_idle_busy", busy, 0);
        check("no_back_to_back_we", b2b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
